// File: rtl/debug_pkg.sv
// debug_pkg: shared constants and helpers for the debug LED peripheral.
//   - Register word indices (DBG_STATUS .. DBG_ID)
//   - ID word vendor/version bytes
//   - STATUS reset value
//   - lane_mask(): expands a 4-bit byte select into a 32-bit bit mask
package debug_pkg;

  localparam logic [31:0] DBG_STATUS = 32'd0;
  localparam logic [31:0] DBG_DATA   = 32'd1;
  localparam logic [31:0] DBG_BLINK  = 32'd2;
  localparam logic [31:0] DBG_DIV    = 32'd3;
  localparam logic [31:0] DBG_DUTY   = 32'd4;
  localparam logic [31:0] DBG_ID     = 32'd5;

  localparam logic [7:0] DBG_ID_VENDOR  = 8'hD6;
  localparam logic [7:0] DBG_ID_VERSION = 8'h02;

  localparam logic DBG_STATUS_RST = 1'b1;

  // Bit-level write enable derived from the byte selects.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/debug_blink.sv
// debug_blink: blink prescaler producing a square-wave phase.
//   clk   - clock
//   rst   - synchronous active-high reset (counter and phase clear)
//   div   - reload value (half-period minus one)
//   load  - restart: counter takes div, phase clears
//   phase - blink phase, toggles every div+1 cycles
module debug_blink #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic             phase
);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (load) begin
      div_cnt <= div;
      phase   <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= div;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/debug_led_wb.sv
// debug_led_wb: Wishbone debug/indicator peripheral.
//   Ports: wb_clk_i/wb_rst_i (sync, active-high), wb_adr_i (word index),
//   wb_dat_i/wb_dat_o, wb_we_i, wb_sel_i (byte lanes), wb_stb_i, wb_cyc_i,
//   wb_ack_o (single-cycle registered ack), led (status), leds[NLEDS].
//   Registers: 0 STATUS, 1 DATA, 2 BLINK, 3 DIV, 4 DUTY, 5 ID (ro).
//   Optional macro DEBUG_LED_PWM_EN adds the DUTY register and global PWM
//   dimming; without it index 4 reads 0 and the bank is never dimmed.
module debug_led_wb
  import debug_pkg::*;
#(
  parameter int NLEDS = 8,
  parameter int DIV_W = 24,
  parameter int PWM_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             led,
  output logic [NLEDS-1:0] leds
);

  // A new access is accepted only when ack is low, so a held strobe
  // alternates accept/ack every other cycle.
  logic acc, wr;
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = acc & wb_we_i;

  logic [31:0] wmask;
  assign wmask = lane_mask(wb_sel_i);

  logic hit_status, hit_data, hit_blink, hit_div;
  assign hit_status = (wb_adr_i == DBG_STATUS);
  assign hit_data   = (wb_adr_i == DBG_DATA);
  assign hit_blink  = (wb_adr_i == DBG_BLINK);
  assign hit_div    = (wb_adr_i == DBG_DIV);

  logic             status_q;
  logic [NLEDS-1:0] data_q, blink_q;
  logic [DIV_W-1:0] div_q;

  // Byte-lane merged write values, truncated to each register's width.
  logic             status_wr;
  logic [NLEDS-1:0] data_wr, blink_wr;
  logic [DIV_W-1:0] div_wr;
  assign status_wr = wmask[0] ? wb_dat_i[0] : status_q;
  assign data_wr   = (data_q  & ~wmask[NLEDS-1:0]) | (wb_dat_i[NLEDS-1:0] & wmask[NLEDS-1:0]);
  assign blink_wr  = (blink_q & ~wmask[NLEDS-1:0]) | (wb_dat_i[NLEDS-1:0] & wmask[NLEDS-1:0]);
  assign div_wr    = (div_q   & ~wmask[DIV_W-1:0]) | (wb_dat_i[DIV_W-1:0] & wmask[DIV_W-1:0]);

  // Any write to DIV restarts the prescaler from the new value.
  logic div_load, phase;
  assign div_load = wr & hit_div;

  debug_blink #(.DIV_W(DIV_W)) u_blink (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .div   (div_load ? div_wr : div_q),
    .load  (div_load),
    .phase (phase)
  );

  logic        pwm_on;
  logic [31:0] rd_duty;
  logic        unused_ok;

`ifdef DEBUG_LED_PWM_EN
  localparam logic PWM_PRESENT = 1'b1;

  logic             hit_duty;
  logic [PWM_W-1:0] duty_q, pwm_cnt, duty_wr;
  assign hit_duty = (wb_adr_i == DBG_DUTY);
  assign duty_wr  = (duty_q & ~wmask[PWM_W-1:0]) | (wb_dat_i[PWM_W-1:0] & wmask[PWM_W-1:0]);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      duty_q  <= '1;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (wr && hit_duty) duty_q <= duty_wr;
    end
  end

  // All-ones duty is forced fully on; the compare alone would drop one slot.
  assign pwm_on  = (duty_q == '1) | (pwm_cnt < duty_q);
  assign rd_duty = 32'(duty_q);
`else
  localparam logic PWM_PRESENT = 1'b0;

  assign pwm_on  = 1'b1;
  assign rd_duty = '0;
`endif

  assign unused_ok = ^{wb_dat_i, wmask};

  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      DBG_STATUS: rd_data = 32'(status_q);
      DBG_DATA:   rd_data = 32'(data_q);
      DBG_BLINK:  rd_data = 32'(blink_q);
      DBG_DIV:    rd_data = 32'(div_q);
      DBG_DUTY:   rd_data = rd_duty;
      DBG_ID:     rd_data = {DBG_ID_VENDOR, 8'(NLEDS), DBG_ID_VERSION, 7'h0, PWM_PRESENT};
      default:    rd_data = '0;
    endcase
  end

  // Blinking LEDs are forced off during the high phase.
  logic [NLEDS-1:0] pre;
  assign pre = data_q & ~(blink_q & {NLEDS{phase}});

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      status_q <= DBG_STATUS_RST;
      data_q   <= '0;
      blink_q  <= '0;
      div_q    <= '0;
      led      <= DBG_STATUS_RST;
      leds     <= '0;
    end else begin
      wb_ack_o <= acc;
      if (acc) wb_dat_o <= rd_data;
      if (wr) begin
        if (hit_status) status_q <= status_wr;
        if (hit_data)   data_q   <= data_wr;
        if (hit_blink)  blink_q  <= blink_wr;
        if (hit_div)    div_q    <= div_wr;
      end
      led  <= status_q;
      leds <= pre & {NLEDS{pwm_on}};
    end
  end

endmodule

// File: tb/tb_debug_led_wb.sv
module tb_debug_led_wb;
  localparam int NLEDS = 8;
  localparam int DIV_W = 24;
  localparam int PWM_W = 8;
`ifdef DEBUG_LED_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      adr = '0, dat = '0, dat_o;
  logic             we = 1'b0, stb = 1'b0, cyc = 1'b0, ack, led;
  logic [3:0]       sel = '0;
  logic [NLEDS-1:0] leds;

  debug_led_wb #(.NLEDS(NLEDS), .DIV_W(DIV_W), .PWM_W(PWM_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(dat_o), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb),
    .wb_cyc_i(cyc), .wb_ack_o(ack), .led(led), .leds(leds)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int ecount = 0, rst_edge = 0, ack_cnt = 0;
  logic [31:0] expq[$];

  // Reference model: architectural register contents plus the edge at
  // which the prescaler last restarted.
  logic [31:0] m_status, m_data, m_blink, m_div, m_duty;
  int load_edge;

  always @(posedge clk) begin
    ecount++;
    if (rst) rst_edge = ecount;
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      0: return m_status;
      1: return m_data;
      2: return m_blink;
      3: return m_div;
      4: return PWM ? m_duty : 32'h0;
      5: return {8'hD6, 8'd8, 8'h02, 7'h0, PWM};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                       input logic [3:0] s, input logic [31:0] keep);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r & keep;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a)
      0: m_status = merge(m_status, d, s, 32'h1);
      1: m_data   = merge(m_data,   d, s, 32'hFF);
      2: m_blink  = merge(m_blink,  d, s, 32'hFF);
      3: begin m_div = merge(m_div, d, s, 32'h00FF_FFFF); load_edge = ecount; end
      4: if (PWM) m_duty = merge(m_duty, d, s, 32'hFF);
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_status = 1; m_data = 0; m_blink = 0; m_div = 0; m_duty = 32'hFF;
  endfunction

  // Expected {led, leds} for the edge after edge n, from register state after n.
  function automatic logic [8:0] model_out(input int n);
    int   ph, cnt;
    bit   on;
    logic [7:0] pre;
    ph  = ((n - load_edge) / (int'(m_div) + 1)) % 2;
    pre = m_data[7:0] & ~(m_blink[7:0] & {8{ph[0]}});
    cnt = (n - rst_edge) % 256;
    on  = !PWM || (m_duty == 32'hFF) || (cnt < int'(m_duty));
    return {m_status[0], on ? pre : 8'h00};
  endfunction

  // Output checker: every cycle out of reset.
  logic [8:0] exp_prev;
  bit chk_en = 0;
  always @(negedge clk) begin
    if (rst) chk_en = 0;
    else begin
      if (!chk_en) begin exp_prev = {1'b1, 8'h00}; chk_en = 1; end
      tests++;
      if ({led, leds} !== exp_prev) begin
        fails++;
        $display("FAIL outputs @edge %0d: got led=%b leds=%h, want led=%b leds=%h",
                 ecount, led, leds, exp_prev[8], exp_prev[7:0]);
      end
      exp_prev = model_out(ecount);
    end
  end

  // Bus monitor: pops the scoreboard whenever ack is presented.
  bit prev_ack = 0;
  logic [31:0] exp_rd;
  always @(negedge clk) begin
    if (ack) begin
      ack_cnt++;
      tests++;
      if (prev_ack) begin
        fails++;
        $display("FAIL ack_consecutive: ack high two cycles in a row, want single pulse");
      end
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got ack with dat_o=%h, want no ack", dat_o);
      end else begin
        exp_rd = expq.pop_front();
        if (dat_o !== exp_rd) begin
          fails++;
          $display("FAIL read_data: got %h, want %h", dat_o, exp_rd);
        end
      end
    end
    prev_ack = ack;
  end

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit w);
    bit got;
    got = 0;
    expq.push_back(model_read(a));
    @(posedge clk); #1;
    adr = a; dat = d; sel = s; we = w; cyc = 1; stb = 1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (ack) got = 1;
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL bus_timeout: no ack for adr %0d, want ack within 20 cycles", a);
      void'(expq.pop_back());
    end else if (w) model_write(a, d, s);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; cyc = 0; stb = 0; we = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    load_edge = rst_edge;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  int hi_cnt, last_t, base;
  logic prev_b0;
  logic [31:0] ra, rd;

  initial begin
    model_reset();
    do_reset();

    // Reset state and ID word.
    @(negedge clk);
    check("reset_led", {31'h0, led}, 32'h1);
    check("reset_leds", {24'h0, leds}, 32'h0);
    check("reset_ack", {31'h0, ack}, 32'h0);
    bus(5, 0, 4'hF, 0);

    // Byte-lane write and all-lanes-off write.
    bus(1, 32'hFFFF_FFA5, 4'b0001, 1);
    @(posedge clk); #1;
    check("lane_write_leds", {24'h0, leds}, 32'hA5);
    bus(1, 32'h0000_005A, 4'b0000, 1);
    repeat (2) @(posedge clk); #1;
    check("sel_none_leds", {24'h0, leds}, 32'hA5);
    bus(1, 0, 4'hF, 0);

    // Blink: bits 1:0 toggle every 4 cycles, others steady.
    bus(1, 32'h0F, 4'hF, 1);
    bus(2, 32'h03, 4'hF, 1);
    bus(3, 32'h03, 4'hF, 1);
    @(negedge clk);
    prev_b0 = leds[0]; last_t = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      check("blink_steady", {24'h0, leds[7:2]}, 32'h03);
      if (leds[0] !== prev_b0) begin
        if (last_t >= 0) check("blink_half_period", t - last_t, 4);
        last_t = t;
      end
      prev_b0 = leds[0];
    end

    // Held strobe: acks only every other cycle; unmapped index reads 0.
    base = ack_cnt;
    repeat (3) expq.push_back(32'h0);
    @(posedge clk); #1;
    adr = 9; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    repeat (6) @(posedge clk);
    #1 cyc = 0; stb = 0;
    @(negedge clk);
    check("held_strobe_acks", ack_cnt - base, 3);
    bus(9, 32'hDEAD_BEEF, 4'hF, 1);
    bus(9, 0, 4'hF, 0);

`ifdef DEBUG_LED_PWM_EN
    bus(2, 0, 4'hF, 1);
    bus(1, 32'h01, 4'hF, 1);
    bus(4, 64, 4'hF, 1);
    repeat (2) @(posedge clk);
    hi_cnt = 0;
    for (int t = 0; t < 256; t++) begin @(negedge clk); hi_cnt += leds[0]; end
    check("pwm_duty64", hi_cnt, 64);
    bus(4, 0, 4'hF, 1);
    repeat (2) @(posedge clk);
    hi_cnt = 0;
    for (int t = 0; t < 256; t++) begin @(negedge clk); hi_cnt += leds[0]; end
    check("pwm_duty0", hi_cnt, 0);
    bus(4, 255, 4'hF, 1);
    repeat (2) @(posedge clk);
    hi_cnt = 0;
    for (int t = 0; t < 256; t++) begin @(negedge clk); hi_cnt += leds[0]; end
    check("pwm_duty255", hi_cnt, 256);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      ra = $urandom_range(0, 9);
      rd = $urandom;
      if (ra == 3) rd = rd & 32'h0000_0307;
      bus(ra, rd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    for (int i = 0; i < 6; i++) bus(i, 0, 4'hF, 0);

    // Reset on the edge that would ack a write of 8'hFF to DATA.
    @(posedge clk); #1;
    adr = 1; dat = 32'hFF; sel = 4'hF; we = 1; cyc = 1; stb = 1; rst = 1;
    model_reset();
    @(posedge clk); #1;
    check("reset_midwrite_ack", {31'h0, ack}, 32'h0);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1 rst = 0;
    load_edge = rst_edge;
    repeat (3) @(posedge clk); #1;
    check("reset_midwrite_leds", {24'h0, leds}, 32'h0);
    check("reset_midwrite_led", {31'h0, led}, 32'h1);
    bus(1, 0, 4'hF, 0);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
